// File: rtl/rt_shift_datapath.sv
// rt_shift_datapath
// Racetrack memory datapath with explicit domain-wall shift control. Memory
// is split into blocks of Nb-word racetracks, each read through Np access
// ports. The block keeps the current port alignment of every racetrack,
// computes the minimum shift distance per request (bidirectional or
// forward-only), emits one shift pulse per cycle, then performs the word
// access against an internal behavioural word store and returns a
// single-cycle response.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   req_i        request valid; accepted when req_i & gnt_o
//   gnt_o        ready (high only in IDLE)
//   we_i         1 = write, 0 = read
//   be_i         byte enables (writes only)
//   addr_i       byte address, addr_i[1:0] ignored
//   wdata_i      write data
//   rdata_o      read data, valid with rvalid_o on reads, held otherwise
//   rvalid_o     one-cycle response strobe
//   err_o        out-of-range flag, valid with rvalid_o
//   shift_o      shift pulse
//   shift_dir_o  1 = forward (+1), 0 = backward (-1)
//   shift_blk_o  block being shifted
//   busy_o       operation in progress
module rt_shift_datapath #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned MAX_SIZE   = 1024,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned Nb         = 32,
   parameter int unsigned Np         = 8,
   parameter int unsigned BIDIR      = 1,
   localparam int unsigned NBLK      = MAX_SIZE / (4 * Nb),
   localparam int unsigned BLK_W     = (NBLK > 1) ? $clog2(NBLK) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    rvalid_o,
   output logic                    err_o,
   output logic                    shift_o,
   output logic                    shift_dir_o,
   output logic [BLK_W-1:0]        shift_blk_o,
   output logic                    busy_o
);

   localparam int unsigned NSP    = Nb / Np;
   localparam int unsigned P_W    = (NSP > 1) ? $clog2(NSP) : 1;
   localparam int unsigned CNT_W  = $clog2(NSP + 1);
   localparam int unsigned NWORDS = MAX_SIZE / 4;
   localparam int unsigned W_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int unsigned NBYTES = DATA_WIDTH / 8;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_ACCESS, ST_RESP} state_t;

   state_t                  r_state;
   logic                    r_gnt;
   logic                    r_busy;
   logic                    r_shift;
   logic                    r_dir;
   logic [BLK_W-1:0]        r_blk;
   logic                    r_rvalid;
   logic                    r_err;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_we;
   logic [NBYTES-1:0]       r_be;
   logic [W_W-1:0]          r_word;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [P_W-1:0]          r_pos [NBLK];
   logic [DATA_WIDTH-1:0]   r_mem [NWORDS];

   logic [ADDR_WIDTH-3:0]   w_word_full;
   logic                    w_oor;
   logic [BLK_W-1:0]        w_blk;
   logic [P_W-1:0]          w_p;
   logic [P_W-1:0]          w_pos;
   logic [P_W-1:0]          w_d;
   logic [CNT_W-1:0]        w_dn;
   logic [CNT_W-1:0]        w_back;
   logic [CNT_W-1:0]        w_n;
   logic                    w_fwd;

   // Request decode and shortest-distance computation. The P_W-bit
   // subtraction wraps modulo NSP because NSP is a power of two.
   always_comb begin
      w_word_full = addr_i[ADDR_WIDTH-1:2];
      w_oor       = (32'(addr_i) >= MAX_SIZE);
      w_blk       = BLK_W'(32'(w_word_full) / Nb);
      w_p         = P_W'((32'(w_word_full) % Nb) % NSP);
      w_pos       = r_pos[w_blk];
      w_d         = w_p - w_pos;
      w_dn        = CNT_W'(w_d);
      w_back      = CNT_W'(NSP) - w_dn;
      w_n         = w_dn;
      w_fwd       = 1'b1;
      // Ties (d == NSP-d) go forward.
      if ((BIDIR != 0) && (w_dn > w_back)) begin
         w_n   = w_back;
         w_fwd = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= ST_IDLE;
         r_gnt    <= 1'b0;
         r_busy   <= 1'b0;
         r_shift  <= 1'b0;
         r_dir    <= 1'b0;
         r_blk    <= '0;
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
         r_cnt    <= '0;
         r_we     <= 1'b0;
         r_be     <= '0;
         r_word   <= '0;
         r_wdata  <= '0;
         for (int unsigned i = 0; i < NBLK; i++) begin
            r_pos[i] <= '0;
         end
      end else begin
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_gnt  <= 1'b1;
               r_busy <= 1'b0;
               if (req_i && r_gnt) begin
                  r_gnt   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_we    <= we_i;
                  r_be    <= be_i;
                  r_word  <= W_W'(w_word_full);
                  r_wdata <= wdata_i;
                  if (w_oor) begin
                     r_state  <= ST_RESP;
                     r_rvalid <= 1'b1;
                     r_err    <= 1'b1;
                  end else if (w_n == '0) begin
                     r_state <= ST_ACCESS;
                  end else begin
                     r_state <= ST_SHIFT;
                     r_shift <= 1'b1;
                     r_dir   <= w_fwd;
                     r_blk   <= w_blk;
                     r_cnt   <= w_n;
                  end
               end
            end
            ST_SHIFT: begin
               // Alignment tracks the pulse currently on shift_o.
               if (r_dir) begin
                  r_pos[r_blk] <= r_pos[r_blk] + P_W'(1);
               end else begin
                  r_pos[r_blk] <= r_pos[r_blk] - P_W'(1);
               end
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_shift <= 1'b0;
                  r_state <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (!r_we) begin
                  r_rdata <= r_mem[r_word];
               end
               r_rvalid <= 1'b1;
               r_state  <= ST_RESP;
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
               r_gnt   <= 1'b1;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Word store is deliberately not reset; a reset mid-operation suppresses
   // the pending write.
   always_ff @(posedge clk_i) begin
      if (!rst_i && (r_state == ST_ACCESS) && r_we) begin
         for (int unsigned i = 0; i < NBYTES; i++) begin
            if (r_be[i]) begin
               r_mem[r_word][8*i +: 8] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

   assign gnt_o       = r_gnt;
   assign busy_o      = r_busy;
   assign shift_o     = r_shift;
   assign shift_dir_o = r_dir;
   assign shift_blk_o = r_blk;
   assign rvalid_o    = r_rvalid;
   assign err_o       = r_err;
   assign rdata_o     = r_rdata;

endmodule

// File: tb/tb_rt_shift_datapath.sv
// Testbench for rt_shift_datapath. Two instances share one request stream:
// index 0 uses shortest-direction shifting, index 1 forward-only. Expected
// responses are pushed to a scoreboard on issue; a monitor consumes them.
module tb_rt_shift_datapath;

   localparam int unsigned NSP  = 4;
   localparam int unsigned NBLK = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [10:0] addr;
   logic [31:0] wdata;

   logic        gnt    [2];
   logic        rvalid [2];
   logic        err    [2];
   logic        shift  [2];
   logic        sdir   [2];
   logic        busy   [2];
   logic [2:0]  sblk   [2];
   logic [31:0] rdata  [2];

   always #5 clk = ~clk;

   rt_shift_datapath #(.ADDR_WIDTH(11), .MAX_SIZE(1024), .DATA_WIDTH(32),
                       .Nb(32), .Np(8), .BIDIR(1)) u_bi (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt[0]), .we_i(we),
      .be_i(be), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata[0]),
      .rvalid_o(rvalid[0]), .err_o(err[0]), .shift_o(shift[0]),
      .shift_dir_o(sdir[0]), .shift_blk_o(sblk[0]), .busy_o(busy[0]));

   rt_shift_datapath #(.ADDR_WIDTH(11), .MAX_SIZE(1024), .DATA_WIDTH(32),
                       .Nb(32), .Np(8), .BIDIR(0)) u_fw (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt[1]), .we_i(we),
      .be_i(be), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata[1]),
      .rvalid_o(rvalid[1]), .err_o(err[1]), .shift_o(shift[1]),
      .shift_dir_o(sdir[1]), .shift_blk_o(sblk[1]), .busy_o(busy[1]));

   typedef struct packed {
      logic            err;
      logic            we;
      logic [31:0]     rdata;
      logic [31:0]     rmask;
      logic [1:0][7:0] n;
      logic [1:0]      fwd;
      logic [7:0]      blk;
      logic [31:0]     acc;
   } exp_t;

   exp_t        sb[$];
   int          h [2];
   int          cyc   = 0;
   int          tests = 0;
   int          fails = 0;
   bit          rst_q = 1'b0;

   int          pos_m [2][NBLK];
   logic [31:0] mem_m [256];
   logic [31:0] kmask [256];

   task automatic chk(input string nm, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)",
                  nm, k, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      rst_q = rst;
   end

   // Monitor
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst_q) begin
            chk("reset_outs", k, {23'd0, gnt[k], rvalid[k], err[k], shift[k],
                                  sdir[k], busy[k], sblk[k]}, 32'd0);
            chk("reset_rdata", k, rdata[k], 32'd0);
         end
         if (rst) begin
            h[k] = sb.size();
         end else if (h[k] < sb.size()) begin
            exp_t e;
            int   rel;
            int   lat;
            bit   exp_sh;
            e      = sb[h[k]];
            rel    = cyc - int'(e.acc);
            lat    = e.err ? 1 : int'(e.n[k]) + 2;
            exp_sh = !e.err && rel >= 1 && rel <= int'(e.n[k]);
            if (rel == 1) chk("gnt_low_busy", k, {31'd0, gnt[k]}, 32'd0);
            if (shift[k] || exp_sh) begin
               chk("shift", k, {31'd0, shift[k]}, {31'd0, exp_sh});
               if (exp_sh) begin
                  chk("shift_dir", k, {31'd0, sdir[k]}, {31'd0, e.fwd[k]});
                  chk("shift_blk", k, {29'd0, sblk[k]}, {24'd0, e.blk});
               end
            end
            if (rvalid[k]) begin
               chk("latency", k, rel, lat);
               chk("err", k, {31'd0, err[k]}, {31'd0, e.err});
               if (!e.we && !e.err)
                  chk("rdata", k, rdata[k] & e.rmask, e.rdata & e.rmask);
               h[k]++;
            end else if (rel >= lat) begin
               chk("rvalid_timeout", k, 32'd0, 32'd1);
               h[k]++;
            end
         end else if (shift[k] || rvalid[k]) begin
            chk("idle_quiet", k, {30'd0, shift[k], rvalid[k]}, 32'd0);
         end
      end
   end

   // Reference model: positions move straight to the target port position;
   // the pulse count is the modular distance in the permitted direction(s).
   task automatic issue(input bit iwe, input logic [3:0] ibe,
                        input logic [10:0] iaddr, input logic [31:0] iwd);
      int   t = 0;
      exp_t e;
      int   w, b, p, d;
      while (!(gnt[0] && gnt[1]) && t < 64) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 64) begin
         chk("grant_wait", 0, 32'd0, 32'd1);
         return;
      end
      e       = '0;
      e.we    = iwe;
      e.acc   = cyc;
      e.err   = (iaddr >= 11'd1024);
      if (!e.err) begin
         w     = int'(iaddr) / 4;
         b     = w / 32;
         p     = (w % 32) % NSP;
         e.blk = 8'(b);
         for (int k = 0; k < 2; k++) begin
            d = (p - pos_m[k][b] + NSP) % NSP;
            if (k == 0 && d > NSP - d) begin
               e.n[k]   = 8'(NSP - d);
               e.fwd[k] = 1'b0;
            end else begin
               e.n[k]   = 8'(d);
               e.fwd[k] = 1'b1;
            end
            pos_m[k][b] = p;
         end
         if (iwe) begin
            for (int i = 0; i < 4; i++) begin
               if (ibe[i]) begin
                  mem_m[w][8*i +: 8] = iwd[8*i +: 8];
                  kmask[w][8*i +: 8] = 8'hFF;
               end
            end
         end else begin
            e.rdata = mem_m[w];
            e.rmask = kmask[w];
         end
      end
      sb.push_back(e);
      req   = 1'b1;
      we    = iwe;
      be    = ibe;
      addr  = iaddr;
      wdata = iwd;
      @(posedge clk); #1;
      req   = 1'b0;
      wdata = $urandom();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      for (int k = 0; k < 2; k++)
         for (int b = 0; b < NBLK; b++) pos_m[k][b] = 0;
   endtask

   initial begin
      int t;
      h[0] = 0; h[1] = 0;
      for (int i = 0; i < 256; i++) begin
         mem_m[i] = '0;
         kmask[i] = '0;
      end
      for (int k = 0; k < 2; k++)
         for (int b = 0; b < NBLK; b++) pos_m[k][b] = 0;
      rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
      @(posedge clk); #1;
      do_reset(3);

      issue(1'b1, 4'hF, 11'h000, 32'hDEADBEEF);
      issue(1'b1, 4'hF, 11'h00C, 32'h12345678);
      issue(1'b0, 4'h0, 11'h00C, 32'h0);
      issue(1'b1, 4'h2, 11'h00C, 32'h0000AB00);
      issue(1'b0, 4'h0, 11'h00C, 32'h0);
      issue(1'b0, 4'h5, 11'h00F, 32'h0);

      // Store survives reset; alignment returns to 0.
      do_reset(2);
      issue(1'b0, 4'h0, 11'h00C, 32'h0);
      issue(1'b0, 4'h0, 11'h088, 32'h0);
      issue(1'b0, 4'h0, 11'h00C, 32'h0);
      issue(1'b0, 4'h0, 11'h400, 32'h0);
      issue(1'b1, 4'h0, 11'h000, 32'hFFFFFFFF);
      issue(1'b0, 4'h0, 11'h000, 32'h0);

      // Abort during the second pulse of the forward-only 3-shift read.
      do_reset(2);
      issue(1'b0, 4'h0, 11'h00C, 32'h0);
      @(posedge clk); #1;
      do_reset(1);
      @(posedge clk); #1;
      chk("gnt_after_rst", 0, {31'd0, gnt[0]}, 32'd1);
      chk("gnt_after_rst", 1, {31'd0, gnt[1]}, 32'd1);
      issue(1'b0, 4'h0, 11'h000, 32'h0);

      for (int i = 0; i < 150; i++) begin
         logic [10:0] a;
         if ($urandom_range(0, 9) == 0) a = 11'($urandom_range(1024, 2047));
         else                           a = 11'($urandom_range(0, 1023));
         issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom());
      end

      t = 0;
      while ((h[0] < sb.size() || h[1] < sb.size()) && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) chk("drain", 0, 32'd0, 32'd1);
      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
